uart_recv: RTL and testbench
============================

UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter CLK_FREQ, default 100000000, SHALL be the clk frequency in Hz.
REQ-003 Parameter BAUD, default 9600, SHALL be the line bit rate; BIT_CNT = CLK_FREQ/BAUD (integer division) SHALL be the clock cycles per bit.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 din  input  1  UART serial line, idle high, asynchronous to clk; connects to the tx output of the send side.
REQ-007 valid  output  1  one-cycle pulse: data holds a newly received good byte.
REQ-008 data  output  8  last good received byte.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 parity_err  output  1  one-cycle pulse: parity mismatch (see REQ-030).
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 din SHALL pass through a 2-flop synchronizer (din_s); all decisions SHALL use din_s only.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; a bit counter cnt (0..BIT_CNT-1) and a bit index idx (0..7) SHALL drive the transitions.
REQ-014 IDLE: when din_s==0, the FSM SHALL enter START with cnt=0.
REQ-015 START: at cnt==BIT_CNT/2-1, the FSM SHALL sample din_s; on 1 (glitch) it SHALL return to IDLE with no output pulse; on 0 it SHALL enter DATA with cnt=0 and idx=0.
REQ-016 DATA: at each cnt==BIT_CNT-1, the FSM SHALL sample din_s into shift-register bit idx (LSB first); after idx==7 it SHALL enter STOP (or PARITY per REQ-030).
REQ-017 STOP: at cnt==BIT_CNT-1, on din_s==1 the block SHALL load data from the shift register, pulse valid for exactly the next cycle and return to IDLE.
REQ-018 STOP sampled 0: the block SHALL pulse frame_err for one cycle, leave data unchanged, and enter WAIT_IDLE.
REQ-019 WAIT_IDLE (line break): the FSM SHALL stay until din_s==1, then go to IDLE.
REQ-020 Samples SHALL fall mid-bit; a new start bit arriving immediately after the stop bit SHALL be received (back-to-back frames with zero idle gap).
REQ-021 valid, frame_err and parity_err SHALL be mutually exclusive and never high for two consecutive cycles.
REQ-022 data SHALL change only in the cycle valid is asserted.
REQ-023 din activity during busy SHALL not restart the frame; only the FSM sampling points SHALL consume it.

Reset
REQ-024 While rst is low, all outputs (valid, frame_err, parity_err, busy and data=8'h00) SHALL be 0 immediately; the FSM SHALL be in IDLE, cnt=0, idx=0, and both synchronizer flops SHALL be 1.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte; the first complete frame after release SHALL be received correctly.

Configuration
REQ-030 With macro UART_RECV_PARITY_EN defined, the FSM SHALL, after idx==7, enter PARITY and sample one even-parity bit at cnt==BIT_CNT-1. On a mismatch it SHALL pulse parity_err at the STOP sample instead of valid, with data unchanged; a low stop bit SHALL still give frame_err only.
REQ-031 Without UART_RECV_PARITY_EN, the frame SHALL be 8N1, PARITY SHALL be unreachable, and parity_err SHALL be tied 0.

Verification (BAUD overridden so that BIT_CNT=10)
REQ-040 Send 8N1 frame 0x55 -> exactly one valid pulse with data=0x55, no error pulses, and busy low afterwards.
REQ-041 Pull din low for 3 cycles, then high -> no valid and no frame_err; busy returns to 0 within 10 cycles.
REQ-042 After 0x55, send 0xA3 with stop bit 0 -> one frame_err pulse, data stays 0x55, FSM holds in WAIT_IDLE until din high.
REQ-043 Send 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses carrying 0x00 then 0xFF.
REQ-044 Assert rst during data bit 4 of 0x81, release, then send 0x3C -> outputs 0 during reset; the only valid pulse carries data=0x3C.
REQ-045 With UART_RECV_PARITY_EN, send 0x07 with parity bit 0 -> one parity_err pulse, no valid; send 0x07 with parity bit 1 -> valid with data=0x07.

Source files
------------

// File: rtl/uart_recv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_recv : mid-bit sampling UART receiver (8N1, or 8E1 with the       |
// |             UART_RECV_PARITY_EN macro defined)                           |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module uart_recv #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       valid,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int CW      = (BIT_CNT > 2) ? $clog2(BIT_CNT) : 1;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] c_CNT_HALF = CW'(BIT_CNT / 2 - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    logic          sync1_q, sync2_q;
    logic          din_s;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
`ifdef UART_RECV_PARITY_EN
    logic          perr_q, perr_d;
    logic          par_bad_q, par_bad_d;
`endif

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    assign din_s = sync2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RECV_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = 3'd0;
                if (!din_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == c_CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = din_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = din_s;
                    if (idx_q == 3'd7) begin
`ifdef UART_RECV_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
`ifdef UART_RECV_PARITY_EN
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = din_s ^ (^shift_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d = '0;
                    if (!din_s) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
`ifdef UART_RECV_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (din_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RECV_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign valid     = valid_q;
    assign data      = data_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_RECV_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_recv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_recv : directed self-checking bench for uart_recv (BIT_CNT = 10) |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_uart_recv;

    localparam int c_BIT = 10;

    logic       clk;
    logic       rst;
    logic       din;
    logic       valid;
    logic [7:0] data;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int         n_cmp;
    int         n_err;
    int         n_valid;
    int         n_ferr;
    int         n_perr;
    int         n_viol;
    logic [7:0] rx_log[$];
    logic       prev_pulse;
    logic [7:0] prev_data;

    uart_recv #(
        .CLK_FREQ (100000000),
        .BAUD     (10000000)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .valid      (valid),
        .data       (data),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse tally plus protocol watch: pulses exclusive, never back-to-back, data moves only with valid.
    always @(negedge clk) begin
        if (rst) begin
            if (valid) begin
                n_valid++;
                rx_log.push_back(data);
            end
            if (frame_err)  n_ferr++;
            if (parity_err) n_perr++;
            if ((32'(valid) + 32'(frame_err) + 32'(parity_err)) > 1) n_viol++;
            if (prev_pulse && (valid || frame_err || parity_err)) n_viol++;
            if ((data != prev_data) && !valid) n_viol++;
        end
        prev_pulse = valid | frame_err | parity_err;
        prev_data  = data;
    end

    task automatic clear_tally();
        n_valid = 0;
        n_ferr  = 0;
        n_perr  = 0;
        rx_log.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        din = b;
        idle(c_BIT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RECV_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) din = 1'b1;
`endif
        send_bit(stp);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        n_viol     = 0;
        prev_pulse = 1'b0;
        prev_data  = 8'h00;
        clear_tally();
        rst = 1'b0;
        din = 1'b1;

        idle(3);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_ferr",  32'(frame_err), 32'd0);
        check_eq("rst_perr",  32'(parity_err), 32'd0);
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_data",  32'(data), 32'h00);
        rst = 1'b1;
        idle(20);

        // 0x55 good frame (even parity bit = 0)
        clear_tally();
        send_frame(8'h55, 1'b0, 1'b1);
        idle(20);
        check_eq("f55_nvalid", 32'(n_valid), 32'd1);
        check_eq("f55_data",   32'(data), 32'h55);
        check_eq("f55_ferr",   32'(n_ferr), 32'd0);
        check_eq("f55_perr",   32'(n_perr), 32'd0);
        check_eq("f55_busy",   32'(busy), 32'd0);

        // 3-cycle glitch
        clear_tally();
        din = 1'b0;
        idle(3);
        din = 1'b1;
        idle(10);
        check_eq("glitch_busy",   32'(busy), 32'd0);
        check_eq("glitch_nvalid", 32'(n_valid), 32'd0);
        check_eq("glitch_ferr",   32'(n_ferr), 32'd0);

        // 0xA3 with low stop bit then line break (0xA3 has 4 ones -> parity 0)
        clear_tally();
        send_frame(8'hA3, 1'b0, 1'b0);
        idle(30);
        check_eq("brk_ferr",   32'(n_ferr), 32'd1);
        check_eq("brk_nvalid", 32'(n_valid), 32'd0);
        check_eq("brk_data",   32'(data), 32'h55);
        check_eq("brk_busy",   32'(busy), 32'd1);
        din = 1'b1;
        idle(10);
        check_eq("brk_release_busy", 32'(busy), 32'd0);
        idle(10);

        // back-to-back 0x00, 0xFF
        clear_tally();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        din = 1'b1;
        idle(20);
        check_eq("b2b_nvalid", 32'(n_valid), 32'd2);
        check_eq("b2b_first",  32'((rx_log.size() > 0) ? rx_log[0] : 8'hEE), 32'h00);
        check_eq("b2b_second", 32'((rx_log.size() > 1) ? rx_log[1] : 8'hEE), 32'hFF);
        check_eq("b2b_ferr",   32'(n_ferr), 32'd0);

        // reset during data bit 4 of 0x81, then 0x3C (4 ones -> parity 0)
        clear_tally();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h81 >> i));
        din = 1'b0;
        idle(5);
        rst = 1'b0;
        idle(1);
        check_eq("mid_rst_busy",  32'(busy), 32'd0);
        check_eq("mid_rst_data",  32'(data), 32'h00);
        check_eq("mid_rst_valid", 32'(valid), 32'd0);
        din = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(20);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(20);
        check_eq("post_rst_nvalid", 32'(n_valid), 32'd1);
        check_eq("post_rst_data",   32'((rx_log.size() > 0) ? rx_log[0] : 8'hEE), 32'h3C);

`ifdef UART_RECV_PARITY_EN
        // 0x07 has three ones -> even parity bit must be 1
        clear_tally();
        send_frame(8'h07, 1'b0, 1'b1);
        idle(20);
        check_eq("par_bad_perr",   32'(n_perr), 32'd1);
        check_eq("par_bad_nvalid", 32'(n_valid), 32'd0);
        check_eq("par_bad_data",   32'(data), 32'h3C);
        clear_tally();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        check_eq("par_ok_nvalid", 32'(n_valid), 32'd1);
        check_eq("par_ok_data",   32'(data), 32'h07);
        check_eq("par_ok_perr",   32'(n_perr), 32'd0);
`endif

        check_eq("protocol_violations", 32'(n_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
